// File: rtl/subleq_circuit.sv
// SUBLEQ computer: CPU core plus unified word-addressed memory.
// Each instruction (A, B, C) does mem[B] = mem[B] - mem[A] and jumps to C
// when the result is <= 0 (signed); otherwise it falls through to pc + 3.
// A taken branch to all-ones parks the machine in HALT until reset.
// Word/address width comes from the WORD_SIZE macro (default 16).
// Optional macro SUBLEQ_SELFLOOP_HALT_EN: a taken branch back to the
// current instruction address also halts.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package subleq_pkg;
  typedef enum logic [2:0] {
    FETCH_A   = 3'd0,
    DEREF_A   = 3'd1,
    FETCH_B   = 3'd2,
    DEREF_B   = 3'd3,
    STORE_SUB = 3'd4,
    FETCH_C   = 3'd5,
    HALT      = 3'd6
  } state_t;
endpackage

// Sequencer for the six-cycle instruction.
// state     | meaning
// FETCH_A   | read mem[pc], latch it as the A address
// DEREF_A   | read mem[A] into areg
// FETCH_B   | read mem[pc+1], latch it as the B address
// DEREF_B   | read mem[B], latch it as the operand
// STORE_SUB | write mem[B] - a back to mem[B], register leq
// FETCH_C   | read mem[pc+2]; branch to it on leq, else pc += 3
// HALT      | absorbing until reset (code 7 also lands here)
module subleq_ctrl
  import subleq_pkg::*;
(
  input  logic   clk,
  input  logic   areset,
  input  logic   leq,
  input  logic   halt_req,
  output state_t state,
  output logic   fetch,
  output logic   deref,
  output logic   load,
  output logic   latch_b,
  output logic   latch_op,
  output logic   store,
  output logic   write,
  output logic   branch,
  output logic   inc
);

  state_t state_next;

  // State register; reset is synchronous and works from any state.
  always_ff @(posedge clk) begin
    if (!areset) state <= FETCH_A;
    else         state <= state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    deref      = 1'b0;
    load       = 1'b0;
    latch_b    = 1'b0;
    latch_op   = 1'b0;
    store      = 1'b0;
    write      = 1'b0;
    branch     = 1'b0;
    inc        = 1'b0;
    case (state)
      FETCH_A: begin
        fetch      = 1'b1;
        state_next = DEREF_A;
      end
      DEREF_A: begin
        deref      = 1'b1;
        load       = 1'b1;
        state_next = FETCH_B;
      end
      FETCH_B: begin
        latch_b    = 1'b1;
        state_next = DEREF_B;
      end
      DEREF_B: begin
        latch_op   = 1'b1;
        state_next = STORE_SUB;
      end
      STORE_SUB: begin
        store      = 1'b1;
        // a reset landing on this edge must not corrupt memory
        write      = areset;
        state_next = FETCH_C;
      end
      FETCH_C: begin
        if (leq) begin
          branch     = 1'b1;
          state_next = halt_req ? HALT : FETCH_A;
        end else begin
          inc        = 1'b1;
          state_next = FETCH_A;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = HALT;
    endcase
  end

endmodule

// Holds mem[A] for the subtraction.
module subleq_areg #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 load,
  input  logic [WORD_SIZE-1:0] d,
  output logic [WORD_SIZE-1:0] a
);

  // Load in DEREF_A, clear on reset.
  always_ff @(posedge clk) begin
    if (!areset)   a <= '0;
    else if (load) a <= d;
  end

endmodule

// CPU datapath: pc, address latches, operand, leq flag, address mux.
module subleq_cpu
  import subleq_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [WORD_SIZE-1:0] data_in_0,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 write
);

  localparam int W = WORD_SIZE;

  logic [W-1:0] pc, pc_addr, a_addr, b_addr;
  logic [W-1:0] data_in_1, data_in_2;
  logic         fetch, deref, load, latch_b, latch_op, store;
  logic         leq, branch, inc, set, halt_req;
  state_t       state;

  subleq_ctrl ctrl (
    .clk      (clk),
    .areset   (areset),
    .leq      (leq),
    .halt_req (halt_req),
    .state    (state),
    .fetch    (fetch),
    .deref    (deref),
    .load     (load),
    .latch_b  (latch_b),
    .latch_op (latch_op),
    .store    (store),
    .write    (write),
    .branch   (branch),
    .inc      (inc)
  );

  subleq_areg #(.WORD_SIZE(W)) areg (
    .clk    (clk),
    .areset (areset),
    .load   (load),
    .d      (data_in_0),
    .a      (data_in_2)
  );

  assign set      = branch;
  assign data_out = data_in_1 - data_in_2;

`ifdef SUBLEQ_SELFLOOP_HALT_EN
  assign halt_req = (data_in_0 == '1) || (data_in_0 == pc);
`else
  assign halt_req = (data_in_0 == '1);
`endif

  // Instruction-word address: pc, pc+1 or pc+2 (wrapping).
  always_comb begin
    pc_addr = pc;
    if (state == FETCH_B)      pc_addr = pc + W'(1);
    else if (state == FETCH_C) pc_addr = pc + W'(2);
  end

  // Memory address: operand addresses during dereference/store.
  always_comb begin
    addr = pc_addr;
    if (deref)                                       addr = a_addr;
    else if (state == DEREF_B || state == STORE_SUB) addr = b_addr;
  end

  // Datapath registers; nothing is strobed in HALT, so it stays frozen.
  always_ff @(posedge clk) begin
    if (!areset) begin
      pc        <= '0;
      a_addr    <= '0;
      b_addr    <= '0;
      data_in_1 <= '0;
      leq       <= 1'b0;
    end else begin
      if (fetch)    a_addr    <= data_in_0;
      if (latch_b)  b_addr    <= data_in_0;
      if (latch_op) data_in_1 <= data_in_0;
      if (store)    leq       <= data_out[W-1] | (data_out == '0);
      if (set)      pc        <= data_in_0;
      else if (inc) pc        <= pc + W'(3);
    end
  end

endmodule

// Unified memory: combinational read, synchronous write, not reset.
module subleq_mem #(
  parameter int    WORD_SIZE = `WORD_SIZE,
  parameter string MEM_INIT  = ""
) (
  input  logic                 clk,
  input  logic                 write,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out
);

  logic [WORD_SIZE-1:0] buffer [0:(2**WORD_SIZE)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (write) buffer[addr] <= data_in;
  end

  assign data_out = buffer[addr];

endmodule

// Top: CPU and memory, driven only by clock and reset.
module subleq_circuit #(
  parameter int    WORD_SIZE = `WORD_SIZE,
  parameter string MEM_INIT  = ""
) (
  input logic clk,
  input logic areset
);

  logic [WORD_SIZE-1:0] addr, mem_rdata, mem_wdata;
  logic                 write;

  subleq_cpu #(.WORD_SIZE(WORD_SIZE)) cpu (
    .clk       (clk),
    .areset    (areset),
    .data_in_0 (mem_rdata),
    .addr      (addr),
    .data_out  (mem_wdata),
    .write     (write)
  );

  subleq_mem #(.WORD_SIZE(WORD_SIZE), .MEM_INIT(MEM_INIT)) mem (
    .clk      (clk),
    .write    (write),
    .addr     (addr),
    .data_in  (mem_wdata),
    .data_out (mem_rdata)
  );

endmodule

// File: tb/tb_subleq_circuit.sv
// Directed bench for subleq_circuit: programs are poked into memory
// hierarchically while reset is held, then state, pc and memory words are
// compared after a fixed number of rising edges.
module tb_subleq_circuit;

  logic clk = 1'b0;
  logic areset = 1'b0;

  subleq_circuit dut (
    .clk    (clk),
    .areset (areset)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] S_FETCH_A = 3'd0, S_FETCH_B = 3'd2, S_STORE = 3'd4,
                         S_FETCH_C = 3'd5, S_HALT = 3'd6;
`ifdef SUBLEQ_SELFLOOP_HALT_EN
  localparam logic [2:0] LOOP_ST = S_HALT;
`else
  localparam logic [2:0] LOOP_ST = S_FETCH_A;
`endif

  typedef struct {
    int          prog;
    int          cycles;
    logic [2:0]  st;
    logic [15:0] pc;
    logic [15:0] maddr;
    logic [15:0] mval;
  } vec_t;

  vec_t vecs[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    dut.mem.buffer[a] = v;
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 65536; i++) dut.mem.buffer[16'(i)] = '0;
    case (p)
      1: begin
        wr(0, 16'h0003); wr(1, 16'h0004); wr(2, 16'hFFFF);
        wr(3, 16'h0005); wr(4, 16'h0002);
      end
      2: begin
        wr(0, 16'h0006); wr(1, 16'h0007); wr(2, 16'h0000);
        wr(3, 16'h0008); wr(4, 16'h0008); wr(5, 16'hFFFF);
        wr(6, 16'h0002); wr(7, 16'h0005);
      end
      3: begin
        wr(0, 16'h0009); wr(1, 16'h000A); wr(2, 16'hFFFF);
        wr(3, 16'h000B); wr(4, 16'h000C); wr(5, 16'hFFFF);
        wr(9, 16'h0001); wr(10, 16'h8000); wr(11, 16'h0002); wr(12, 16'h0001);
      end
      4: begin
        wr(0, 16'd20); wr(1, 16'd22); wr(2, 16'd3);
        wr(3, 16'd22); wr(4, 16'd21); wr(5, 16'd6);
        wr(6, 16'd22); wr(7, 16'd22); wr(8, 16'd9);
        wr(9, 16'd22); wr(10, 16'd22); wr(11, 16'hFFFF);
        wr(20, 16'd7); wr(21, 16'd5); wr(22, 16'd0);
      end
      5: begin
        wr(0, 16'h0030); wr(1, 16'h0030); wr(2, 16'hFFFE);
        wr(4, 16'h0030); wr(5, 16'h0030); wr(6, 16'hFFFF);
        wr(16'hFFFE, 16'h0031); wr(16'hFFFF, 16'h0032);
        wr(16'h0031, 16'h0001); wr(16'h0032, 16'h0005);
      end
      default: begin
        wr(0, 16'h0030); wr(1, 16'h0030); wr(2, 16'h0010);
        wr(16'h10, 16'h0030); wr(16'h11, 16'h0030); wr(16'h12, 16'h0010);
      end
    endcase
  endtask

  // Hold reset for two edges with the program loaded, then release.
  task automatic start(input int p);
    areset = 1'b0;
    load_prog(p);
    tick;
    tick;
    areset = 1'b1;
  endtask

  task automatic add(input int p, input int c, input logic [2:0] st,
                     input logic [15:0] pc, input logic [15:0] ma, input logic [15:0] mv);
    vec_t v;
    v.prog = p; v.cycles = c; v.st = st; v.pc = pc; v.maddr = ma; v.mval = mv;
    vecs.push_back(v);
  endtask

  initial begin
    add(1,  5, S_FETCH_C, 16'h0000, 16'h0004, 16'hFFFD);
    add(1,  6, S_HALT,    16'hFFFF, 16'h0003, 16'h0005);
    add(1, 16, S_HALT,    16'hFFFF, 16'h0004, 16'hFFFD);
    add(2,  6, S_FETCH_A, 16'h0003, 16'h0007, 16'h0003);
    add(2, 12, S_HALT,    16'hFFFF, 16'h0008, 16'h0000);
    add(3,  6, S_FETCH_A, 16'h0003, 16'h000A, 16'h7FFF);
    add(3, 12, S_HALT,    16'hFFFF, 16'h000C, 16'hFFFF);
    add(4, 23, S_FETCH_C, 16'h0009, 16'h0015, 16'h000C);
    add(4, 24, S_HALT,    16'hFFFF, 16'h0015, 16'h000C);
    add(4, 24, S_HALT,    16'hFFFF, 16'h0016, 16'h0000);
    add(5,  6, S_FETCH_A, 16'hFFFE, 16'h0030, 16'h0000);
    add(5, 12, S_FETCH_A, 16'h0001, 16'h0032, 16'h0004);
    add(5, 18, S_FETCH_A, 16'h0004, 16'hFFFE, 16'h0031);
    add(5, 24, S_HALT,    16'hFFFF, 16'h0032, 16'h0004);
    add(6, 12, LOOP_ST,   16'h0010, 16'h0030, 16'h0000);
    add(6, 18, LOOP_ST,   16'h0010, 16'h0030, 16'h0000);

    foreach (vecs[i]) begin
      start(vecs[i].prog);
      repeat (vecs[i].cycles) tick;
      check($sformatf("v%0d_state", i), 16'(dut.cpu.ctrl.state), 16'(vecs[i].st));
      check($sformatf("v%0d_pc", i), dut.cpu.pc, vecs[i].pc);
      check($sformatf("v%0d_mem", i), dut.mem.buffer[vecs[i].maddr], vecs[i].mval);
    end

    // Reset state and areg load timing.
    start(1);
    check("rst_state", 16'(dut.cpu.ctrl.state), 16'(S_FETCH_A));
    check("rst_pc", dut.cpu.pc, 16'h0000);
    check("rst_areg", dut.cpu.areg.a, 16'h0000);
    tick; tick;
    check("areg_loaded", dut.cpu.areg.a, 16'h0005);
    check("st_fetch_b", 16'(dut.cpu.ctrl.state), 16'(S_FETCH_B));

    // Reset landing on the STORE_SUB edge suppresses the write.
    tick; tick;
    check("st_store", 16'(dut.cpu.ctrl.state), 16'(S_STORE));
    areset = 1'b0;
    tick;
    check("rst_store_mem", dut.mem.buffer[4], 16'h0002);
    check("rst_store_state", 16'(dut.cpu.ctrl.state), 16'(S_FETCH_A));
    check("rst_store_pc", dut.cpu.pc, 16'h0000);
    check("rst_store_areg", dut.cpu.areg.a, 16'h0000);
    areset = 1'b1;
    repeat (6) tick;
    check("rerun_state", 16'(dut.cpu.ctrl.state), 16'(S_HALT));
    check("rerun_mem", dut.mem.buffer[4], 16'hFFFD);

    // HALT is absorbing, reset recovers from it, memory survives reset.
    repeat (8) tick;
    check("halt_hold_mem", dut.mem.buffer[4], 16'hFFFD);
    check("halt_hold_areg", dut.cpu.areg.a, 16'h0005);
    areset = 1'b0;
    tick;
    check("rst_halt_state", 16'(dut.cpu.ctrl.state), 16'(S_FETCH_A));
    check("rst_halt_pc", dut.cpu.pc, 16'h0000);
    areset = 1'b1;
    repeat (6) tick;
    check("second_run_mem", dut.mem.buffer[4], 16'hFFF8);
    check("second_run_state", 16'(dut.cpu.ctrl.state), 16'(S_HALT));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
